// File: rtl/bnn_seq_ctrl.sv
// Instruction sequencer for the BNN accelerator: fetches 16-bit instructions,
// runs a small register file with loop/branch control and issues core and data-SRAM commands.
module bnn_seq_ctrl #(
   parameter int unsigned IADDR_W = 11,
   parameter int unsigned DADDR_W = 13,
   parameter int unsigned REG_W   = 16,
   parameter int unsigned ARG_W   = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause,
   output logic               busy,
   output logic               done,
   output logic [IADDR_W-1:0] inst_addr,
   output logic               inst_cen,
   input  logic [15:0]        inst_rdata,
   output logic [DADDR_W-1:0] data_addr,
   output logic               data_cen,
   output logic               data_wen,
   output logic               core_valid,
   output logic [4:0]         core_op,
   output logic [ARG_W-1:0]   core_arg
);

   localparam int unsigned OP_W  = 5;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned IMM_W = 8;
   localparam int unsigned NREGS = 8;

   localparam logic [OP_W-1:0] OP_LDL   = 5'b00001;
   localparam logic [OP_W-1:0] OP_LDH   = 5'b00010;
   localparam logic [OP_W-1:0] OP_LOAD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_ADDI  = 5'b00100;
   localparam logic [OP_W-1:0] OP_CMP   = 5'b00101;
   localparam logic [OP_W-1:0] OP_BNZ   = 5'b00110;
   localparam logic [OP_W-1:0] OP_CORE0 = 5'b00111;
   localparam logic [OP_W-1:0] OP_CORE1 = 5'b01000;
   localparam logic [OP_W-1:0] OP_CORE2 = 5'b01001;
   localparam logic [OP_W-1:0] OP_CORE3 = 5'b01010;
   localparam logic [OP_W-1:0] OP_STORE = 5'b01011;
   localparam logic [OP_W-1:0] OP_CORE4 = 5'b01100;
   localparam logic [OP_W-1:0] OP_DJNZ  = 5'b01101;
   localparam logic [OP_W-1:0] OP_HALT  = 5'b11111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t               state;
   logic [IADDR_W-1:0]   pc;
   logic [REG_W-1:0]     regs [NREGS];

   logic [OP_W-1:0]      opcode;
   logic [IDX_W-1:0]     rd_idx;
   logic [IMM_W-1:0]     imm;
   logic [REG_W-1:0]     rd_val;

   logic                 wr_en;
   logic [IDX_W-1:0]     wr_idx;
   logic [REG_W-1:0]     wr_val;
   logic [IADDR_W-1:0]   pc_next;
   logic                 strobe;
   logic                 acc;
   logic                 acc_wr;
   logic [DADDR_W-1:0]   acc_addr;
   logic                 halt;

   assign inst_addr = pc;
   assign opcode    = inst_rdata[15:11];
   assign rd_idx    = inst_rdata[10:8];
   assign imm       = inst_rdata[7:0];
   assign rd_val    = (rd_idx == '0) ? '0 : regs[rd_idx];

   // Instruction decode: one register write, next pc and command request per instruction.
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = rd_idx;
      wr_val   = rd_val;
      pc_next  = pc + IADDR_W'(1);
      strobe   = 1'b0;
      acc      = 1'b0;
      acc_wr   = 1'b0;
      acc_addr = data_addr;
      halt     = 1'b0;
      case (opcode)
         OP_LDL: begin
            wr_en         = 1'b1;
            wr_val[7:0]   = imm;
         end
         OP_LDH: begin
            wr_en         = 1'b1;
            wr_val[15:8]  = imm;
         end
         OP_ADDI: begin
            wr_en  = 1'b1;
            wr_val = rd_val + {{(REG_W-IMM_W){imm[IMM_W-1]}}, imm};
         end
         OP_CMP: begin
            wr_en  = 1'b1;
            wr_idx = IDX_W'(1);
            wr_val = (rd_val < REG_W'(imm)) ? REG_W'(1) : '0;
         end
         OP_BNZ: begin
            if (regs[1] != '0) pc_next = pc - IADDR_W'(inst_rdata[10:0]);
         end
         OP_DJNZ: begin
            // R0 stays zero, so a DJNZ on R0 never takes the branch
            wr_en  = (rd_idx != '0);
            wr_val = rd_val - REG_W'(1);
            if (rd_idx != '0 && wr_val != '0) pc_next = pc - IADDR_W'(imm);
         end
         OP_LOAD: begin
            strobe   = 1'b1;
            acc      = 1'b1;
            acc_addr = regs[2][DADDR_W-1:0];
            wr_en    = 1'b1;
            wr_idx   = IDX_W'(2);
            wr_val   = inst_rdata[0] ? regs[2] + REG_W'(1) : regs[2] - REG_W'(1);
         end
         OP_STORE: begin
            strobe   = 1'b1;
            acc      = 1'b1;
            acc_wr   = 1'b1;
            acc_addr = regs[3][DADDR_W-1:0];
            wr_en    = 1'b1;
            wr_idx   = IDX_W'(3);
            wr_val   = inst_rdata[0] ? regs[3] + REG_W'(1) : regs[3] - REG_W'(1);
         end
         OP_CORE0, OP_CORE1, OP_CORE2, OP_CORE3, OP_CORE4: begin
            strobe = 1'b1;
         end
         OP_HALT: begin
            halt    = 1'b1;
            pc_next = pc;
         end
         default: ;
      endcase
   end

   // Sequencer FSM; strobes fall back to inactive every cycle unless re-issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         core_valid <= 1'b0;
         core_op    <= '0;
         core_arg   <= '0;
         inst_cen   <= 1'b1;
         data_cen   <= 1'b1;
         data_wen   <= 1'b1;
         data_addr  <= '0;
      end else begin
         done       <= 1'b0;
         core_valid <= 1'b0;
         inst_cen   <= 1'b1;
         data_cen   <= 1'b1;
         data_wen   <= 1'b1;
         if (!pause) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     pc       <= '0;
                     state    <= FETCH;
                     busy     <= 1'b1;
                     inst_cen <= 1'b0;
                  end
               end
               FETCH: state <= EXEC;
               EXEC: begin
                  pc <= pc_next;
                  if (wr_en && wr_idx != '0) regs[wr_idx] <= wr_val;
                  if (strobe) begin
                     core_valid <= 1'b1;
                     core_op    <= opcode;
                     core_arg   <= ARG_W'(inst_rdata[10:0]);
                  end
                  if (acc) begin
                     data_cen  <= 1'b0;
                     data_wen  <= ~acc_wr;
                     data_addr <= acc_addr;
                  end
                  if (halt) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state    <= FETCH;
                     inst_cen <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
